// File: rtl/gci_std_display_bus_request_queue_if.sv
// Bus-side and controller-side handshake bundle for the display bus request queue.
// The queue connects through the slave modport; the bus/controller environment uses master.
interface gci_std_display_bus_request_queue_if #(
  parameter int P_DEPTH_N = 4
);
  logic                 iBUS_REQ;
  logic                 oBUS_BUSY;
  logic                 iBUS_RW;
  logic [31:0]          iBUS_ADDR;
  logic [31:0]          iBUS_DATA;
  logic                 oBUS_RD_VALID;
  logic                 iBUS_RD_BUSY;
  logic [31:0]          oBUS_RD_DATA;
  logic                 oIF_WR_REQ;
  logic                 iIF_WR_BUSY;
  logic                 oIF_WR_RW;
  logic [31:0]          oIF_WR_ADDR;
  logic [31:0]          oIF_WR_DATA;
  logic                 iIF_RD_VALID;
  logic                 oIF_RD_BUSY;
  logic [31:0]          iIF_RD_DATA;
  logic [P_DEPTH_N:0]   oCOUNT;
  logic                 oERR_TIMEOUT;

  modport slave (
    input  iBUS_REQ, iBUS_RW, iBUS_ADDR, iBUS_DATA, iBUS_RD_BUSY,
           iIF_WR_BUSY, iIF_RD_VALID, iIF_RD_DATA,
    output oBUS_BUSY, oBUS_RD_VALID, oBUS_RD_DATA,
           oIF_WR_REQ, oIF_WR_RW, oIF_WR_ADDR, oIF_WR_DATA,
           oIF_RD_BUSY, oCOUNT, oERR_TIMEOUT
  );

  modport master (
    output iBUS_REQ, iBUS_RW, iBUS_ADDR, iBUS_DATA, iBUS_RD_BUSY,
           iIF_WR_BUSY, iIF_RD_VALID, iIF_RD_DATA,
    input  oBUS_BUSY, oBUS_RD_VALID, oBUS_RD_DATA,
           oIF_WR_REQ, oIF_WR_RW, oIF_WR_ADDR, oIF_WR_DATA,
           oIF_RD_BUSY, oCOUNT, oERR_TIMEOUT
  );
endinterface

// File: rtl/gci_std_display_bus_request_queue.sv
// In-order command queue between the bus and the display controller.
// Commands issue one at a time; a read blocks further issue until its response
// (or a timeout error reply) has been handed back to the bus.
module gci_std_display_bus_request_queue #(
  parameter int P_DEPTH_N    = 4,
  parameter int P_RD_TIMEOUT = 1023
) (
  input  logic iCLOCK,
  input  logic iRESET_SYNC,
  gci_std_display_bus_request_queue_if.slave bus
);

  localparam int DEPTH = 2 ** P_DEPTH_N;
  localparam int TW    = (P_RD_TIMEOUT > 1) ? $clog2(P_RD_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]      TIMEOUT_VAL = TW'(P_RD_TIMEOUT);
  localparam logic [P_DEPTH_N:0] FULL_COUNT  = (P_DEPTH_N + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t                 mem_q [DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_N:0]   count_q, count_d;
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [31:0]          rd_data_q, rd_data_d;

  logic empty, full, push, pop, timeout_hit;
  cmd_t head, push_cmd;

  // Next-state logic for pointers, occupancy, read tracking FSM and response data
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FULL_COUNT);
    push        = bus.iBUS_REQ && !full;
    pop         = (state_q == ST_ISSUE) && !empty && !bus.iIF_WR_BUSY;
    head        = mem_q[rd_ptr_q];
    push_cmd    = '{rw: bus.iBUS_RW, addr: bus.iBUS_ADDR, data: bus.iBUS_DATA};
    timeout_hit = (state_q == ST_WAIT_RD) && (P_RD_TIMEOUT != 0) &&
                  (timer_q == TIMEOUT_VAL) && !bus.iIF_RD_VALID;

    wr_ptr_d  = push ? wr_ptr_q + P_DEPTH_N'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + P_DEPTH_N'(1) : rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    timer_d   = timer_q;
    rd_data_d = rd_data_q;

    if (push && !pop) begin
      count_d = count_q + (P_DEPTH_N + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (P_DEPTH_N + 1)'(1);
    end

    case (state_q)
      ST_ISSUE: begin
        if (pop && !head.rw) begin
          state_d = ST_WAIT_RD;
          timer_d = '0;
        end
      end
      ST_WAIT_RD: begin
        timer_d = timer_q + TW'(1);
        if (bus.iIF_RD_VALID) begin
          rd_data_d = bus.iIF_RD_DATA;
          state_d   = ST_RESP;
        end else if (timeout_hit) begin
          rd_data_d = 32'hFFFF_FFFF;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!bus.iBUS_RD_BUSY) begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  // Control and FSM registers; reset discards everything in flight
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_ISSUE;
      timer_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Command storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge iCLOCK) begin
    if (push && !iRESET_SYNC) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  assign bus.oBUS_BUSY     = full;
  assign bus.oIF_WR_REQ    = (state_q == ST_ISSUE) && !empty;
  assign bus.oIF_WR_RW     = empty ? 1'b0  : head.rw;
  assign bus.oIF_WR_ADDR   = empty ? 32'h0 : head.addr;
  assign bus.oIF_WR_DATA   = empty ? 32'h0 : head.data;
  assign bus.oIF_RD_BUSY   = (state_q != ST_WAIT_RD);
  assign bus.oBUS_RD_VALID = (state_q == ST_RESP);
  assign bus.oBUS_RD_DATA  = rd_data_q;
  assign bus.oCOUNT        = count_q;
  assign bus.oERR_TIMEOUT  = timeout_hit;

endmodule

// File: tb/tb_gci_std_display_bus_request_queue.sv
// Scoreboard bench for the display bus request queue: directed stimulus pushes
// expected issues/responses into queues, negedge monitors pop and compare.
module tb_gci_std_display_bus_request_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gci_std_display_bus_request_queue_if #(.P_DEPTH_N(4)) bif ();

  gci_std_display_bus_request_queue #(
    .P_DEPTH_N   (4),
    .P_RD_TIMEOUT(8)
  ) dut (
    .iCLOCK     (clk),
    .iRESET_SYNC(rst),
    .bus        (bif.slave)
  );

  int checks     = 0;
  int errors     = 0;
  int pulses     = 0;
  int exp_pulses = 0;
  logic [64:0] exp_issue [$];
  logic [31:0] exp_resp  [$];

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [64:0] actual, input logic [64:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rw, input logic [31:0] a, input logic [31:0] d);
    bif.iBUS_REQ  = 1'b1;
    bif.iBUS_RW   = rw;
    bif.iBUS_ADDR = a;
    bif.iBUS_DATA = d;
    tick();
    bif.iBUS_REQ  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (n < 100 && !(bif.oCOUNT == 0 && bif.oIF_RD_BUSY && !bif.oBUS_RD_VALID)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL %s drain_timeout count=%0d required=0", name, bif.oCOUNT);
    end
  endtask

  // Issue monitor: every accepted downstream command must match the next expected one
  always @(negedge clk) begin
    if (!rst && bif.oIF_WR_REQ && !bif.iIF_WR_BUSY) begin
      if (exp_issue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_issue actual=%0h required=none",
                 {bif.oIF_WR_RW, bif.oIF_WR_ADDR, bif.oIF_WR_DATA});
      end else begin
        check_output("issue", {bif.oIF_WR_RW, bif.oIF_WR_ADDR, bif.oIF_WR_DATA}, exp_issue.pop_front());
      end
    end
  end

  // Response monitor: every read response taken by the bus must match the next expected data
  always @(negedge clk) begin
    if (!rst && bif.oBUS_RD_VALID && !bif.iBUS_RD_BUSY) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_response actual=%0h required=none", bif.oBUS_RD_DATA);
      end else begin
        check_output("response", {33'h0, bif.oBUS_RD_DATA}, {33'h0, exp_resp.pop_front()});
      end
    end
  end

  // Timeout pulse counter
  always @(negedge clk) begin
    if (!rst && bif.oERR_TIMEOUT) pulses++;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    int k;
    bif.iBUS_REQ     = 1'b0;
    bif.iBUS_RW      = 1'b0;
    bif.iBUS_ADDR    = '0;
    bif.iBUS_DATA    = '0;
    bif.iBUS_RD_BUSY = 1'b0;
    bif.iIF_WR_BUSY  = 1'b0;
    bif.iIF_RD_VALID = 1'b0;
    bif.iIF_RD_DATA  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_count",    {60'h0, bif.oCOUNT}, 65'd0);
    check_output("rst_busy",     {64'h0, bif.oBUS_BUSY}, 65'd0);
    check_output("rst_wr_req",   {64'h0, bif.oIF_WR_REQ}, 65'd0);
    check_output("rst_rd_valid", {64'h0, bif.oBUS_RD_VALID}, 65'd0);
    check_output("rst_rd_busy",  {64'h0, bif.oIF_RD_BUSY}, 65'd1);
    check_output("rst_rd_data",  {33'h0, bif.oBUS_RD_DATA}, 65'd0);
    check_output("rst_err",      {64'h0, bif.oERR_TIMEOUT}, 65'd0);
    tick();

    // Single write, one-cycle latency to issue
    exp_issue.push_back({1'b1, 32'h10, 32'h00FF00});
    apply_stimulus(1'b1, 32'h10, 32'h00FF00);
    @(negedge clk);
    check_output("t1_wr_req", {64'h0, bif.oIF_WR_REQ}, 65'd1);
    tick();
    @(negedge clk);
    check_output("t1_count_after_pop", {60'h0, bif.oCOUNT}, 65'd0);
    tick();

    // Fill to full while stalled, overflow push ignored, then in-order drain
    bif.iIF_WR_BUSY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_issue.push_back({1'b1, 32'h10 + 32'(i), 32'hA000 + 32'(i)});
      apply_stimulus(1'b1, 32'h10 + 32'(i), 32'hA000 + 32'(i));
    end
    @(negedge clk);
    check_output("t2_count_full", {60'h0, bif.oCOUNT}, 65'd16);
    check_output("t2_busy_full",  {64'h0, bif.oBUS_BUSY}, 65'd1);
    tick();
    apply_stimulus(1'b1, 32'h99, 32'hBAD);
    @(negedge clk);
    check_output("t2_count_overflow", {60'h0, bif.oCOUNT}, 65'd16);
    tick();
    bif.iIF_WR_BUSY = 1'b0;
    drain("t2");

    // Read then write: write waits until the read response is taken
    bif.iBUS_RD_BUSY = 1'b1;
    exp_issue.push_back({1'b0, 32'h4, 32'h0});
    apply_stimulus(1'b0, 32'h4, 32'h0);
    exp_issue.push_back({1'b1, 32'h20, 32'h55});
    apply_stimulus(1'b1, 32'h20, 32'h55);
    @(negedge clk);
    check_output("t3_wait_rd_accepts", {64'h0, bif.oIF_RD_BUSY}, 65'd0);
    check_output("t3_wait_rd_no_req",  {64'h0, bif.oIF_WR_REQ}, 65'd0);
    tick();
    repeat (3) tick();
    bif.iIF_RD_VALID = 1'b1;
    bif.iIF_RD_DATA  = 32'h1234;
    exp_resp.push_back(32'h1234);
    tick();
    bif.iIF_RD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t3_resp_valid_held", {64'h0, bif.oBUS_RD_VALID}, 65'd1);
      check_output("t3_resp_data_held",  {33'h0, bif.oBUS_RD_DATA}, {33'h0, 32'h1234});
      check_output("t3_write_blocked",   {64'h0, bif.oIF_WR_REQ}, 65'd0);
      tick();
    end
    bif.iBUS_RD_BUSY = 1'b0;
    drain("t3");

    // Unanswered read times out after 8 cycles in WAIT_RD
    exp_issue.push_back({1'b0, 32'h8, 32'h0});
    apply_stimulus(1'b0, 32'h8, 32'h0);
    tick();
    exp_resp.push_back(32'hFFFF_FFFF);
    exp_pulses++;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bif.oERR_TIMEOUT) break;
      tick();
      k++;
    end
    check_output("t4_timeout_delay", 65'(k), 65'd8);
    tick();
    tick();
    bif.iIF_RD_VALID = 1'b1;
    bif.iIF_RD_DATA  = 32'hDEAD;
    @(negedge clk);
    check_output("t4_late_data_refused", {64'h0, bif.oIF_RD_BUSY}, 65'd1);
    check_output("t4_no_late_resp",      {64'h0, bif.oBUS_RD_VALID}, 65'd0);
    check_output("t4_rd_data_holds",     {33'h0, bif.oBUS_RD_DATA}, {33'h0, 32'hFFFF_FFFF});
    tick();
    bif.iIF_RD_VALID = 1'b0;

    // Read data arriving in the timeout cycle wins, no pulse
    exp_issue.push_back({1'b0, 32'hC, 32'h0});
    apply_stimulus(1'b0, 32'hC, 32'h0);
    tick();
    repeat (8) tick();
    bif.iIF_RD_VALID = 1'b1;
    bif.iIF_RD_DATA  = 32'hCAFE;
    exp_resp.push_back(32'hCAFE);
    tick();
    bif.iIF_RD_VALID = 1'b0;
    drain("t4b");

    // Steady push+pop at occupancy 3 across the pointer wrap
    bif.iIF_WR_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_issue.push_back({1'b1, 32'h300 + 32'(i), 32'h5000 + 32'(i)});
      apply_stimulus(1'b1, 32'h300 + 32'(i), 32'h5000 + 32'(i));
    end
    bif.iIF_WR_BUSY = 1'b0;
    for (int i = 3; i < 23; i++) begin
      bif.iBUS_REQ  = 1'b1;
      bif.iBUS_RW   = 1'b1;
      bif.iBUS_ADDR = 32'h300 + 32'(i);
      bif.iBUS_DATA = 32'h5000 + 32'(i);
      exp_issue.push_back({1'b1, 32'h300 + 32'(i), 32'h5000 + 32'(i)});
      @(negedge clk);
      check_output("t5_count_steady", {60'h0, bif.oCOUNT}, 65'd3);
      tick();
    end
    bif.iBUS_REQ = 1'b0;
    drain("t5");

    // Reset in the middle of a read with five entries queued
    exp_issue.push_back({1'b0, 32'h40, 32'h0});
    apply_stimulus(1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 32'h400 + 32'(i), 32'h77);
    end
    @(negedge clk);
    check_output("t6_pre_count",   {60'h0, bif.oCOUNT}, 65'd5);
    check_output("t6_pre_wait_rd", {64'h0, bif.oIF_RD_BUSY}, 65'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("t6_count",    {60'h0, bif.oCOUNT}, 65'd0);
    check_output("t6_wr_req",   {64'h0, bif.oIF_WR_REQ}, 65'd0);
    check_output("t6_rd_valid", {64'h0, bif.oBUS_RD_VALID}, 65'd0);
    check_output("t6_issue",    {64'h0, bif.oIF_RD_BUSY}, 65'd1);
    repeat (5) tick();

    // Everything expected must have been observed
    check_output("end_issue_left", 65'(exp_issue.size()), 65'd0);
    check_output("end_resp_left",  65'(exp_resp.size()), 65'd0);
    check_output("end_pulses",     65'(pulses), 65'(exp_pulses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
